// File: rtl/svec_fd_pkg.sv
// svec_fd_pkg: shared constants and FSM state type for the SVEC fine-delay bring-up slave
package svec_fd_pkg;
    localparam logic [15:0] RSTR_OFF     = 16'h0000;
    localparam logic [15:0] IDR_OFF      = 16'h0004;
    localparam logic [15:0] CH_BASE      = 16'h0100;
    localparam logic [15:0] RSTR_KEY     = 16'hDEAD;
    localparam logic [5:0]  AM_A32_USER  = 6'h09;
    localparam logic [5:0]  AM_A32_SUPER = 6'h0D;
    localparam logic [31:0] WIN_BASE     = 32'h0004_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_DTACK,
        S_WAIT_END
    } state_t;

    function automatic logic am_ok(input logic [5:0] am);
        return am == AM_A32_USER || am == AM_A32_SUPER;
    endfunction
endpackage

// File: rtl/fd_slot_regs.sv
// fd_slot_regs: per-slot keyed reset register, constant ID and four channel registers
module fd_slot_regs
    import svec_fd_pkg::*;
#(
    parameter logic [31:0] g_fd_idr = 32'hF19EDE1A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [15:0] offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        fd_rst_n,
    output logic        core_rst_n
);
    logic [1:0]  rstr;
    logic [31:0] ch [4];
    logic        is_ch;

    assign is_ch = offset[15:4] == CH_BASE[15:4] && offset[1:0] == 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstr <= '0;
            ch   <= '{default: '0};
        end else begin
            if (we && offset == RSTR_OFF && wdata[31:16] == RSTR_KEY)
                rstr <= wdata[1:0];
            for (int i = 0; i < 4; i++)
                ch[i] <= !rstr[1] ? '0 : (we && is_ch && offset[3:2] == 2'(i)) ? wdata : ch[i];
        end
    end

    assign rdata = offset == RSTR_OFF ? {30'h0, rstr} :
                   offset == IDR_OFF  ? g_fd_idr :
                   is_ch              ? ch[offset[3:2]] : '0;

    assign fd_rst_n   = rstr[0];
    assign core_rst_n = rstr[1];
endmodule

// File: rtl/svec_top.sv
// svec_top: VME64x A32/D32 single-cycle slave exposing two FD slot register windows
module svec_top
    import svec_fd_pkg::*;
#(
    parameter int          g_simulation = 0,
    parameter logic [31:0] g_fd_idr     = 32'hF19EDE1A
) (
    input  logic        clk_125m_pllref_p_i,
    input  logic        rst_n_i,
    input  logic        vme_as_n_i,
    input  logic [1:0]  vme_ds_n_i,
    input  logic        vme_write_n_i,
    input  logic [5:0]  vme_am_i,
    input  logic        vme_lword_n_i,
    input  logic [30:0] vme_addr_i,
    input  logic [31:0] vme_data_i,
    output logic [31:0] vme_data_o,
    output logic        vme_data_oe_n_o,
    output logic        vme_data_dir_o,
    output logic        vme_dtack_n_o,
    output logic        vme_dtack_oe_o,
    output logic        fd0_rst_n_o,
    output logic        fd1_rst_n_o,
    output logic        fd0_core_rst_n_o,
    output logic        fd1_core_rst_n_o
);
    logic        clk, rst_n;
    logic        as_m, as_s, wr_m, wr_s;
    logic [1:0]  ds_m, ds_s;
    logic [31:2] addr_q;
    logic [5:0]  am_q;
    logic        lword_q;
    logic [31:0] wdata_q;
    state_t      state, state_n;
    logic        accept, sel, drive_data;
    logic [15:0] offset;
    logic [31:0] rdata0, rdata1;
    logic        we0, we1;
    logic        unused_bits;

    assign clk         = clk_125m_pllref_p_i;
    assign rst_n       = rst_n_i;
    assign unused_bits = ^{vme_addr_i[0], g_simulation != 0};

    assign accept = am_ok(am_q) && !lword_q && ds_s == 2'b00 && addr_q[31:17] == WIN_BASE[31:17];
    assign sel    = addr_q[16];
    assign offset = {addr_q[15:2], 2'b00};
    assign we0    = state == S_ACCESS && !wr_s && !sel;
    assign we1    = state == S_ACCESS && !wr_s && sel;
    assign drive_data = wr_s && (state_n == S_ACCESS || state_n == S_DTACK);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     state_n = (!as_s && ds_s == 2'b00) ? S_DECODE : S_IDLE;
            S_DECODE:   state_n = as_s ? S_IDLE : accept ? S_ACCESS : S_WAIT_END;
            S_ACCESS:   state_n = as_s ? S_IDLE : S_DTACK;
            S_DTACK:    state_n = (ds_s == 2'b11) ? S_WAIT_END : S_DTACK;
            S_WAIT_END: state_n = as_s ? S_IDLE : S_WAIT_END;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {as_m, as_s, wr_m, wr_s} <= '1;
            ds_m            <= '1;
            ds_s            <= '1;
            addr_q          <= '0;
            am_q            <= '0;
            lword_q         <= 1'b1;
            wdata_q         <= '0;
            state           <= S_IDLE;
            vme_dtack_n_o   <= 1'b1;
            vme_dtack_oe_o  <= 1'b0;
            vme_data_oe_n_o <= 1'b1;
            vme_data_dir_o  <= 1'b0;
            vme_data_o      <= '0;
        end else begin
            {as_s, as_m} <= {as_m, vme_as_n_i};
            {wr_s, wr_m} <= {wr_m, vme_write_n_i};
            ds_m         <= vme_ds_n_i;
            ds_s         <= ds_m;
            if (!as_s) begin
                addr_q  <= vme_addr_i[30:1];
                am_q    <= vme_am_i;
                lword_q <= vme_lword_n_i;
                wdata_q <= vme_data_i;
            end
            state           <= state_n;
            vme_dtack_n_o   <= state_n != S_DTACK;
            // OE stays up through WAIT_END only for cycles that actually acknowledged
            vme_dtack_oe_o  <= state_n == S_DTACK || (state_n == S_WAIT_END && vme_dtack_oe_o);
            vme_data_dir_o  <= drive_data;
            vme_data_oe_n_o <= !drive_data;
            vme_data_o      <= (state_n == S_ACCESS && wr_s) ? (sel ? rdata1 : rdata0) : vme_data_o;
        end
    end

    fd_slot_regs #(.g_fd_idr(g_fd_idr)) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we0),
        .offset     (offset),
        .wdata      (wdata_q),
        .rdata      (rdata0),
        .fd_rst_n   (fd0_rst_n_o),
        .core_rst_n (fd0_core_rst_n_o)
    );

    fd_slot_regs #(.g_fd_idr(g_fd_idr)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we1),
        .offset     (offset),
        .wdata      (wdata_q),
        .rdata      (rdata1),
        .fd_rst_n   (fd1_rst_n_o),
        .core_rst_n (fd1_core_rst_n_o)
    );
endmodule

// File: tb/tb_svec_top.sv
// tb_svec_top: directed VME cycles against svec_top with a read-data scoreboard
module tb_svec_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        as_n, write_n, lword_n;
    logic [1:0]  ds_n;
    logic [5:0]  am;
    logic [30:0] addr;
    logic [31:0] din;
    logic [31:0] vme_data_o;
    logic        vme_data_oe_n_o, vme_data_dir_o, vme_dtack_n_o, vme_dtack_oe_o;
    logic        fd0_rst_n_o, fd1_rst_n_o, fd0_core_rst_n_o, fd1_core_rst_n_o;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb [$];

    always #4 clk = ~clk;

    svec_top dut (
        .clk_125m_pllref_p_i (clk),
        .rst_n_i             (rst_n),
        .vme_as_n_i          (as_n),
        .vme_ds_n_i          (ds_n),
        .vme_write_n_i       (write_n),
        .vme_am_i            (am),
        .vme_lword_n_i       (lword_n),
        .vme_addr_i          (addr),
        .vme_data_i          (din),
        .vme_data_o          (vme_data_o),
        .vme_data_oe_n_o     (vme_data_oe_n_o),
        .vme_data_dir_o      (vme_data_dir_o),
        .vme_dtack_n_o       (vme_dtack_n_o),
        .vme_dtack_oe_o      (vme_dtack_oe_o),
        .fd0_rst_n_o         (fd0_rst_n_o),
        .fd1_rst_n_o         (fd1_rst_n_o),
        .fd0_core_rst_n_o    (fd0_core_rst_n_o),
        .fd1_core_rst_n_o    (fd1_core_rst_n_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [5:0] am_v, input logic wr,
                         input logic [31:0] d, output int lat, output bit oe_seen);
        @(posedge clk); #1;
        addr = a[31:1]; am = am_v; lword_n = 1'b0; write_n = !wr; din = d; as_n = 1'b0;
        @(posedge clk); #1;
        ds_n = 2'b00; lat = 0; oe_seen = 1'b0;
        while (lat < 20 && vme_dtack_n_o) begin
            @(posedge clk); #1;
            lat++;
            oe_seen |= vme_dtack_oe_o;
        end
    endtask

    task automatic finish_cycle(input bit acked);
        int n = 0;
        ds_n = 2'b11;
        if (acked) begin
            while (n < 10 && !vme_dtack_n_o) begin
                @(posedge clk); #1;
                n++;
            end
            chk("dtack_release_within_3", 32'(n <= 3), 32'd1);
            chk("dir_release", 32'(vme_data_dir_o), 32'd0);
        end
        as_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [5:0] am_v,
                            input logic [31:0] d);
        int lat;
        bit oe;
        start(a, am_v, 1'b1, d, lat, oe);
        chk({tag, "_lat"}, lat, 32'd5);
        chk({tag, "_dir"}, 32'(vme_data_dir_o), 32'd0);
        finish_cycle(lat < 20);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int lat;
        bit oe;
        sb.push_back(exp);
        start(a, 6'h09, 1'b0, 32'h0, lat, oe);
        chk({tag, "_lat"}, lat, 32'd5);
        if (lat < 20) begin
            chk({tag, "_dir"}, 32'(vme_data_dir_o), 32'd1);
            chk({tag, "_oe_n"}, 32'(vme_data_oe_n_o), 32'd0);
            chk(tag, vme_data_o, sb.pop_front());
        end else begin
            void'(sb.pop_front());
        end
        finish_cycle(lat < 20);
    endtask

    task automatic do_reject(input string tag, input logic [31:0] a, input logic [5:0] am_v,
                             input logic [31:0] d);
        int lat;
        bit oe;
        start(a, am_v, 1'b1, d, lat, oe);
        chk({tag, "_no_dtack"}, lat, 32'd20);
        chk({tag, "_no_dtack_oe"}, 32'(oe), 32'd0);
        chk({tag, "_no_data_oe"}, 32'(vme_data_oe_n_o), 32'd1);
        finish_cycle(1'b0);
    endtask

    initial begin
        int lat;
        bit oe;
        rst_n = 1'b0; as_n = 1'b1; ds_n = 2'b11; write_n = 1'b1;
        am = '0; lword_n = 1'b1; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dtack_n", 32'(vme_dtack_n_o), 32'd1);
        chk("rst_dtack_oe", 32'(vme_dtack_oe_o), 32'd0);
        chk("rst_data_oe_n", 32'(vme_data_oe_n_o), 32'd1);
        chk("rst_data_dir", 32'(vme_data_dir_o), 32'd0);
        chk("rst_data_o", vme_data_o, 32'h0);
        chk("rst_fd_resets", 32'({fd0_rst_n_o, fd0_core_rst_n_o, fd1_rst_n_o, fd1_core_rst_n_o}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_read("idr_slot0", 32'h0004_0004, 32'hF19EDE1A);
        do_read("idr_slot1", 32'h0005_0004, 32'hF19EDE1A);

        do_write("ch0_slot0_in_reset_wr", 32'h0004_0100, 6'h09, 32'hDEADBEEF);
        do_read("ch0_slot0_in_reset", 32'h0004_0100, 32'h0);

        do_write("rstr0_unreset", 32'h0004_0000, 6'h09, 32'hDEADFFFF);
        chk("fd0_rst_n", 32'(fd0_rst_n_o), 32'd1);
        chk("fd0_core_rst_n", 32'(fd0_core_rst_n_o), 32'd1);
        chk("fd1_unchanged", 32'({fd1_rst_n_o, fd1_core_rst_n_o}), 32'd0);
        do_read("rstr0_readback", 32'h0004_0000, 32'h0000_0003);

        do_write("rstr1_bad_key", 32'h0005_0000, 6'h0D, 32'hBEEF0003);
        chk("fd1_still_reset", 32'({fd1_rst_n_o, fd1_core_rst_n_o}), 32'd0);
        do_read("rstr1_readback", 32'h0005_0000, 32'h0);

        do_write("ch0_slot0_wr", 32'h0004_0100, 6'h09, 32'hDEADBEEF);
        do_read("ch0_slot0", 32'h0004_0100, 32'hDEADBEEF);
        do_write("ch3_slot0_wr", 32'h0004_010C, 6'h0D, 32'h1234_5678);
        do_read("ch3_slot0", 32'h0004_010C, 32'h1234_5678);
        do_read("ch1_slot0_untouched", 32'h0004_0104, 32'h0);

        do_write("rstr1_core_only", 32'h0005_0000, 6'h09, 32'hDEAD0002);
        chk("fd1_rst_n_core_only", 32'({fd1_rst_n_o, fd1_core_rst_n_o}), 32'b01);
        do_write("ch2_slot1_wr", 32'h0005_0108, 6'h09, 32'hCAFE_F00D);
        do_read("ch2_slot1", 32'h0005_0108, 32'hCAFE_F00D);
        do_read("ch2_slot0_isolated", 32'h0004_0108, 32'h0);
        do_read("unmapped_offset", 32'h0004_0200, 32'h0);

        do_reject("outside_window", 32'h0006_0000, 6'h09, 32'hDEAD0000);
        do_reject("bad_am", 32'h0004_0000, 6'h39, 32'hDEAD0000);
        chk("fd0_after_rejects", 32'({fd0_rst_n_o, fd0_core_rst_n_o}), 32'b11);
        do_read("ch0_after_rejects", 32'h0004_0100, 32'hDEADBEEF);

        start(32'h0004_0004, 6'h09, 1'b0, 32'h0, lat, oe);
        chk("dtack_exact_5", lat, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_dtack_n", 32'(vme_dtack_n_o), 32'd1);
        chk("midrst_dtack_oe", 32'(vme_dtack_oe_o), 32'd0);
        chk("midrst_data_dir", 32'(vme_data_dir_o), 32'd0);
        chk("midrst_data_oe_n", 32'(vme_data_oe_n_o), 32'd1);
        chk("midrst_fd0_resets", 32'({fd0_rst_n_o, fd0_core_rst_n_o}), 32'd0);
        ds_n = 2'b11;
        as_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_read("rstr0_after_midrst", 32'h0004_0000, 32'h0);
        do_read("ch0_after_midrst", 32'h0004_0100, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/svec_top.md
# svec_top

Simplified SVEC carrier top level: a VME64x A32/D32 single-cycle slave that exposes register windows for two FMC fine-delay (FD) mezzanine slots. Each slot window provides a keyed reset register, a constant ID register and four channel registers, and drives the slot reset lines. This block sits directly behind the board VME buffers and replaces the full VME core, White Rabbit and FD cores for bring-up.

## Interface
Parameters:
- g_simulation, 0, ignored by logic; kept for top-level compatibility.
- g_fd_idr, 32'hF19EDE1A, value returned by every slot IDR.

Ports:
- clk_125m_pllref_p_i  in  1  single system clock, 125 MHz.
- rst_n_i  in  1  asynchronous, active-low reset.
- vme_as_n_i  in  1  address strobe.
- vme_ds_n_i  in  2  data strobes.
- vme_write_n_i  in  1  0 = write.
- vme_am_i  in  6  address modifier.
- vme_lword_n_i  in  1  0 = 32-bit transfer.
- vme_addr_i  in  31  A[31:1].
- vme_data_i  in  32  D from bus.
- vme_data_o  out  32  D to bus.
- vme_data_oe_n_o  out  1  data buffer enable, active low.
- vme_data_dir_o  out  1  1 = board drives bus.
- vme_dtack_n_o  out  1  DTACK.
- vme_dtack_oe_o  out  1  DTACK buffer enable.
- fd0_rst_n_o, fd1_rst_n_o  out  1  FMC reset per slot, active low.
- fd0_core_rst_n_o, fd1_core_rst_n_o  out  1  core reset per slot, active low.

## Operation
- as_n, ds_n[1:0] and write_n are synchronized through 2 flops. Address, AM, lword and data are sampled when the synchronized as_n is low.
- A cycle is accepted only if all of the following hold:
  - AM is 0x09 or 0x0D.
  - lword_n = 0.
  - Both DS are low.
  - A[31:17] = 15'h0002, i.e. the window 0x40000–0x5FFFF.
- For any other cycle, DTACK and the data outputs are never driven. No BERR is generated.
- Slot select: A[16]. 0 selects slot 0 (0x40000); 1 selects slot 1 (0x50000).
- Byte offset within a slot is {A[15:2],2'b00}:
  - 0x000 RSTR (R/W). A write updates bits [1:0] only if D[31:16] = 16'hDEAD; otherwise it is ignored. Bit0 drives fdN_rst_n_o, bit1 drives fdN_core_rst_n_o. Reads return {16'h0, 14'h0, bits[1:0]}.
  - 0x004 IDR (RO): returns g_fd_idr.
  - 0x100, 0x104, 0x108, 0x10C: CH0–CH3 (R/W, 32 bit). Held at 0 and writes ignored while RSTR bit1 = 0.
  - Any other offset: read returns 0, write ignored, cycle still acknowledged.
- Registered outputs (RSTR, channel registers, VME outputs) are cleared on reset, so both slots power up in reset. fdN_rst_n_o and fdN_core_rst_n_o follow RSTR bits 0 and 1 combinationally from the register flops.
- FSM states and transitions:
  - IDLE → DECODE when synchronized AS and both DS are low.
  - DECODE → ACCESS if the cycle is accepted; otherwise DECODE → WAIT_END.
  - ACCESS performs the register write, or latches read data into vme_data_o. ACCESS → DTACK.
  - DTACK asserts vme_dtack_n_o = 0. DTACK → WAIT_END when the synchronized DS go high.
  - WAIT_END → IDLE when the synchronized AS is high.
- A write takes effect exactly once per strobe cycle.

## Timing
- Reset values:
  - vme_dtack_n_o = 1, vme_dtack_oe_o = 0.
  - vme_data_oe_n_o = 1, vme_data_dir_o = 0, vme_data_o = 0.
  - All fd*_rst_n_o = 0.
- Latency: DTACK goes low at the 5th rising clock after DS falls (2 sync + DECODE + ACCESS + DTACK).
- For reads: vme_data_dir_o = 1 and vme_data_oe_n_o = 0 from ACCESS onward; vme_data_o is valid at least 1 cycle before DTACK falls.
- vme_dtack_oe_o = 1 from DTACK state through WAIT_END.
- DTACK releases within 3 clocks after DS rises. The data direction returns to 0 at the same time.
- AS rising mid-cycle (before DTACK) aborts the cycle to IDLE with no register side effects, unless ACCESS has already executed.
- rst_n_i asserted mid-cycle resets the FSM to IDLE immediately; all outputs take their reset values.

## Structure
- Shared package svec_fd_pkg holds:
  - Register offsets: RSTR 0x000, IDR 0x004, CH base 0x100.
  - RSTR key 16'hDEAD.
  - Accepted AM codes.
  - Window base 0x40000.
  - FSM state typedef.
- One sub-module, fd_slot_regs, instantiated twice. It contains the RSTR, IDR and CH0–3 registers, a write strobe, an offset input, read data out, and the reset outputs.

## Test plan
- After reset, read 0x40004 and 0x50004 → both return 0xF19EDE1A. fd0/fd1 resets are low.
- Write 0xDEADFFFF to 0x40000 → fd0_rst_n_o = 1 and fd0_core_rst_n_o = 1; fd1 unchanged; read back 0x00000003.
- Write 0xBEEF0003 to 0x50000 → ignored (wrong key); fd1 resets stay low.
- Write 0xDEADBEEF to 0x40100 before un-reset → reads 0. Repeat after un-reset → reads 0xDEADBEEF.
- Access 0x60000, or use AM = 0x39 → DTACK never asserts.
- Timing check: DTACK falls exactly 5 clocks after DS falls. Assert rst_n_i during DTACK → DTACK releases immediately and RSTR clears.
